// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared types and default sizes for the datapath_p slice:
//               ALU operation codes, write-back select codes, flag positions.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // Default sizes used by the datapath and its register file
    localparam int c_DEF_DATA_W   = 16;
    localparam int c_DEF_RF_DEPTH = 16;
    localparam int c_DEF_DM_DEPTH = 256;

    // Bit positions inside the {N,Z,C,V} flag word
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    // ALU operation codes (ALU_s)
    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_SHL  = 3'b111
    } alu_op_e;

    // Register write-back source codes (RF_s); the reserved code behaves as ALU
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_IMM  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/datapath_p_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : Register file, two combinational read ports, one synchronous
//               write port. Register 0 always reads zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import datapath_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = c_DEF_RF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_ra_addr,
    input  logic [$clog2(DEPTH)-1:0] i_rb_addr,
    output logic [DATA_W-1:0]        o_ra_data,
    output logic [DATA_W-1:0]        o_rb_data
);

    // Entry 0 exists only to keep indexing simple; it is never written and
    // is masked on both read ports.
    logic [DATA_W-1:0] r_regs [0:DEPTH-1];

    // Storage update: clear everything on reset, otherwise write any non-zero index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Reads see the pre-edge contents, so read-during-write returns the old value
    always_comb begin
        o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
        o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];
    end

endmodule : regfile
`default_nettype wire

// File: rtl/datapath_p.sv
`default_nettype none
// ============================================================================
// Module      : datapath_p
// Description : Simple processor datapath: register file, 8-op ALU with
//               {N,Z,C,V} flag register, single-port data memory with a
//               registered read, and a write-back select mux.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_p
    import datapath_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int RF_DEPTH = c_DEF_RF_DEPTH,
    parameter int DM_DEPTH = c_DEF_DM_DEPTH
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [$clog2(DM_DEPTH)-1:0] D_Addr,
    input  logic                        D_Wr,
    input  logic [1:0]                  RF_s,
    input  logic [DATA_W-1:0]           Imm,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_W_Addr,
    input  logic                        RF_W_en,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_Ra_Addr,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_Rb_Addr,
    input  logic [2:0]                  ALU_s,
    input  logic                        Flag_en,
    output logic [DATA_W-1:0]           ALU_inA,
    output logic [DATA_W-1:0]           ALU_inB,
    output logic [DATA_W-1:0]           ALU_out,
    output logic [3:0]                  Flags,
    output logic [DATA_W-1:0]           D_Rd
);

    localparam int c_MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rb;
    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_flags_nxt;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_drd;
    logic [DATA_W-1:0] r_mem [0:DM_DEPTH-1];

    regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (RF_DEPTH)
    ) u_regfile (
        .clk       (Clk),
        .rst       (Reset),
        .i_wr_en   (RF_W_en),
        .i_wr_addr (RF_W_Addr),
        .i_wr_data (w_wb_data),
        .i_ra_addr (RF_Ra_Addr),
        .i_rb_addr (RF_Rb_Addr),
        .o_ra_data (w_ra),
        .o_rb_data (w_rb)
    );

    // ALU: one extra bit on add/sub exposes carry and borrow
    always_comb begin
        w_sum  = {1'b0, w_ra} + {1'b0, w_rb};
        w_diff = {1'b0, w_ra} - {1'b0, w_rb};
        w_alu  = w_ra;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (alu_op_e'(ALU_s))
            ALU_PASS: w_alu = w_ra;
            ALU_ADD: begin
                w_alu = w_sum[c_MSB:0];
                w_c   = w_sum[DATA_W];
                // Same-sign operands producing an opposite-sign result
                w_v   = (w_ra[c_MSB] == w_rb[c_MSB]) && (w_sum[c_MSB] != w_ra[c_MSB]);
            end
            ALU_SUB: begin
                w_alu = w_diff[c_MSB:0];
                // Borrow out of the extended subtract is set exactly when A < B
                w_c   = ~w_diff[DATA_W];
                w_v   = (w_ra[c_MSB] != w_rb[c_MSB]) && (w_diff[c_MSB] != w_ra[c_MSB]);
            end
            ALU_AND:  w_alu = w_ra & w_rb;
            ALU_OR:   w_alu = w_ra | w_rb;
            ALU_XOR:  w_alu = w_ra ^ w_rb;
            ALU_NOT:  w_alu = ~w_ra;
            ALU_SHL: begin
                w_alu = {w_ra[c_MSB-1:0], 1'b0};
                w_c   = w_ra[c_MSB];
            end
            default:  w_alu = w_ra;
        endcase
    end

    // Candidate flag word derived from the current ALU result
    always_comb begin
        w_flags_nxt           = '0;
        w_flags_nxt[c_FLAG_N] = w_alu[c_MSB];
        w_flags_nxt[c_FLAG_Z] = (w_alu == '0);
        w_flags_nxt[c_FLAG_C] = w_c;
        w_flags_nxt[c_FLAG_V] = w_v;
    end

    // Write-back source select; the reserved code falls through to the ALU
    always_comb begin
        case (wb_sel_e'(RF_s))
            WB_MEM:  w_wb_data = r_drd;
            WB_IMM:  w_wb_data = Imm;
            default: w_wb_data = w_alu;
        endcase
    end

    // Flag register: cleared by reset, loaded only when enabled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flags <= '0;
        end else if (Flag_en) begin
            r_flags <= w_flags_nxt;
        end
    end

    // Data memory array: no reset on contents, writes blocked while in reset
    always_ff @(posedge Clk) begin
        if (!Reset && D_Wr) begin
            r_mem[D_Addr] <= w_rb;
        end
    end

    // Registered read port; a same-address write lands after this sample,
    // so the old word is returned
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_drd <= '0;
        end else begin
            r_drd <= r_mem[D_Addr];
        end
    end

    assign ALU_inA = w_ra;
    assign ALU_inB = w_rb;
    assign ALU_out = w_alu;
    assign Flags   = r_flags;
    assign D_Rd    = r_drd;

endmodule : datapath_p
`default_nettype wire

// File: tb/tb_datapath_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_p
// Description : Self-checking bench for datapath_p: directed scenarios plus
//               randomized traffic compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_p;

    localparam int W = 16;

    logic          Clk;
    logic          Reset;
    logic [7:0]    D_Addr;
    logic          D_Wr;
    logic [1:0]    RF_s;
    logic [W-1:0]  Imm;
    logic [3:0]    RF_W_Addr;
    logic          RF_W_en;
    logic [3:0]    RF_Ra_Addr;
    logic [3:0]    RF_Rb_Addr;
    logic [2:0]    ALU_s;
    logic          Flag_en;
    logic [W-1:0]  ALU_inA;
    logic [W-1:0]  ALU_inB;
    logic [W-1:0]  ALU_out;
    logic [3:0]    Flags;
    logic [W-1:0]  D_Rd;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [W-1:0] m_regs [0:15];
    logic [W-1:0] m_mem  [0:255];
    logic [3:0]   m_flags;
    logic [W-1:0] m_drd;

    datapath_p dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .Imm        (Imm),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s      (ALU_s),
        .Flag_en    (Flag_en),
        .ALU_inA    (ALU_inA),
        .ALU_inB    (ALU_inB),
        .ALU_out    (ALU_out),
        .Flags      (Flags),
        .D_Rd       (D_Rd)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ALU behaviour from plain integer arithmetic
    function automatic void m_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, full, s;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: full = ua;
            3'd1: begin
                full = ua + ub;
                c = (full > 65535);
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: begin
                full = ua - ub;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd3: full = ua & ub;
            3'd4: full = ua | ub;
            3'd5: full = ua ^ ub;
            3'd6: full = 65535 - ua;
            default: begin
                full = ua * 2;
                c = (ua >= 32768);
            end
        endcase
        r = 16'(full);
        f = {r[W-1], (r == 16'h0000), c, v};
    endfunction

    // Advance one clock, updating the model from the inputs being applied
    task automatic step();
        logic [W-1:0] a, b, res, wb, nd;
        logic [3:0] fl;
        a = m_regs[RF_Ra_Addr];
        b = m_regs[RF_Rb_Addr];
        m_alu(ALU_s, a, b, res, fl);
        if (Reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_flags = '0;
            m_drd   = '0;
        end else begin
            case (RF_s)
                2'b01:   wb = m_drd;
                2'b10:   wb = Imm;
                default: wb = res;
            endcase
            nd = m_mem[D_Addr];
            if (D_Wr) m_mem[D_Addr] = b;
            if (RF_W_en && RF_W_Addr != 4'd0) m_regs[RF_W_Addr] = wb;
            if (Flag_en) m_flags = fl;
            m_drd = nd;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset = 0; D_Addr = '0; D_Wr = 0; RF_s = 2'b00; Imm = '0;
        RF_W_Addr = '0; RF_W_en = 0; RF_Ra_Addr = '0; RF_Rb_Addr = '0;
        ALU_s = 3'b000; Flag_en = 0;
    endtask

    task automatic load_imm(input logic [3:0] r, input logic [W-1:0] v);
        idle();
        RF_s = 2'b10; Imm = v; RF_W_Addr = r; RF_W_en = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1;
        step();
        step();
        idle();
        RF_Ra_Addr = 4'd5; RF_Rb_Addr = 4'd9;
        #1;
        n_checks++;
        if (Flags !== 4'h0) begin n_errors++; $display("FAIL reset_flags: got %h want 0", Flags); end
        n_checks++;
        if (D_Rd !== 16'h0) begin n_errors++; $display("FAIL reset_drd: got %h want 0", D_Rd); end
        n_checks++;
        if (ALU_inA !== 16'h0 || ALU_inB !== 16'h0) begin
            n_errors++; $display("FAIL reset_regs: got A=%h B=%h want 0", ALU_inA, ALU_inB);
        end
    endtask

    // Give every memory word a known value before it can be read back
    task automatic preload_mem();
        for (int i = 0; i < 256; i++) begin
            idle();
            RF_s = 2'b10; Imm = 16'($urandom); RF_W_Addr = 4'd1; RF_W_en = 1;
            RF_Rb_Addr = 4'd1; D_Wr = 1; D_Addr = 8'(i);
            step();
        end
        idle();
    endtask

    task automatic test_imm_add();
        load_imm(4'd1, 16'd5);
        load_imm(4'd2, 16'd3);
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd2; ALU_s = 3'b001;
        #1;
        n_checks++;
        if (ALU_out !== 16'd8) begin n_errors++; $display("FAIL imm_add_out: got %h want 0008", ALU_out); end
        n_checks++;
        if (ALU_inA !== 16'd5 || ALU_inB !== 16'd3) begin
            n_errors++; $display("FAIL imm_add_in: got A=%h B=%h want 0005 0003", ALU_inA, ALU_inB);
        end
    endtask

    task automatic test_flags();
        load_imm(4'd3, 16'h7FFF);
        load_imm(4'd5, 16'h0001);
        RF_Ra_Addr = 4'd3; RF_Rb_Addr = 4'd5; ALU_s = 3'b001; Flag_en = 1;
        step();
        n_checks++;
        if (Flags !== 4'b1001) begin n_errors++; $display("FAIL flags_add_ovf: got %b want 1001", Flags); end
        idle();
        RF_Ra_Addr = 4'd2; RF_Rb_Addr = 4'd2; ALU_s = 3'b010; Flag_en = 1;
        step();
        n_checks++;
        if (Flags !== 4'b0110) begin n_errors++; $display("FAIL flags_sub_eq: got %b want 0110", Flags); end
        idle();
        RF_Ra_Addr = 4'd3; RF_Rb_Addr = 4'd5; ALU_s = 3'b001; Flag_en = 0;
        step();
        n_checks++;
        if (Flags !== 4'b0110) begin n_errors++; $display("FAIL flags_hold: got %b want 0110", Flags); end
        idle();
        RF_Ra_Addr = 4'd3; ALU_s = 3'b111; Flag_en = 1;
        #1;
        n_checks++;
        if (ALU_out !== 16'hFFFE) begin n_errors++; $display("FAIL shl_out: got %h want fffe", ALU_out); end
        step();
        n_checks++;
        if (Flags !== 4'b1000) begin n_errors++; $display("FAIL flags_shl: got %b want 1000", Flags); end
        idle();
    endtask

    task automatic test_mem();
        load_imm(4'd6, 16'hBEEF);
        RF_Rb_Addr = 4'd6; D_Wr = 1; D_Addr = 8'h10;
        step();
        idle();
        D_Addr = 8'h10;
        step();
        n_checks++;
        if (D_Rd !== 16'hBEEF) begin n_errors++; $display("FAIL mem_read: got %h want beef", D_Rd); end
        D_Addr = 8'h10; RF_s = 2'b01; RF_W_Addr = 4'd4; RF_W_en = 1;
        step();
        idle();
        RF_Ra_Addr = 4'd4;
        #1;
        n_checks++;
        if (ALU_inA !== 16'hBEEF) begin n_errors++; $display("FAIL mem_writeback: got %h want beef", ALU_inA); end
        // Same-address write and read: old word first, new word next cycle
        RF_Rb_Addr = 4'd2; D_Wr = 1; D_Addr = 8'h10;
        step();
        n_checks++;
        if (D_Rd !== 16'hBEEF) begin n_errors++; $display("FAIL mem_rdw_old: got %h want beef", D_Rd); end
        idle();
        D_Addr = 8'h10;
        step();
        n_checks++;
        if (D_Rd !== 16'h0003) begin n_errors++; $display("FAIL mem_rdw_new: got %h want 0003", D_Rd); end
    endtask

    task automatic test_r0_rdw();
        load_imm(4'd0, 16'hFFFF);
        RF_Ra_Addr = 4'd0;
        #1;
        n_checks++;
        if (ALU_inA !== 16'h0) begin n_errors++; $display("FAIL r0_zero: got %h want 0000", ALU_inA); end
        RF_s = 2'b10; Imm = 16'h1234; RF_W_Addr = 4'd1; RF_W_en = 1; RF_Ra_Addr = 4'd1;
        #1;
        n_checks++;
        if (ALU_inA !== 16'd5) begin n_errors++; $display("FAIL rdw_old: got %h want 0005", ALU_inA); end
        step();
        idle();
        RF_Ra_Addr = 4'd1;
        #1;
        n_checks++;
        if (ALU_inA !== 16'h1234) begin n_errors++; $display("FAIL rdw_new: got %h want 1234", ALU_inA); end
    endtask

    task automatic test_reset_priority();
        load_imm(4'd7, 16'hAAAA);
        Reset = 1; RF_s = 2'b10; Imm = 16'h5555; RF_W_Addr = 4'd7; RF_W_en = 1;
        RF_Ra_Addr = 4'd7; RF_Rb_Addr = 4'd7; ALU_s = 3'b010; Flag_en = 1;
        D_Wr = 1; D_Addr = 8'h10;
        step();
        idle();
        RF_Ra_Addr = 4'd7; RF_Rb_Addr = 4'd1;
        #1;
        n_checks++;
        if (Flags !== 4'h0 || D_Rd !== 16'h0) begin
            n_errors++; $display("FAIL rstpri_flags_drd: got F=%b D=%h want 0 0", Flags, D_Rd);
        end
        n_checks++;
        if (ALU_inA !== 16'h0 || ALU_inB !== 16'h0) begin
            n_errors++; $display("FAIL rstpri_regs: got A=%h B=%h want 0", ALU_inA, ALU_inB);
        end
        // First edge after deassertion behaves normally
        D_Addr = 8'h10; RF_s = 2'b10; Imm = 16'h0009; RF_W_Addr = 4'd1; RF_W_en = 1;
        step();
        idle();
        RF_Ra_Addr = 4'd1;
        #1;
        n_checks++;
        if (D_Rd !== 16'h0003) begin n_errors++; $display("FAIL rstpri_mem_kept: got %h want 0003", D_Rd); end
        n_checks++;
        if (ALU_inA !== 16'h0009) begin n_errors++; $display("FAIL rstpri_resume: got %h want 0009", ALU_inA); end
    endtask

    task automatic test_random();
        logic [W-1:0] er;
        logic [3:0] ef;
        for (int i = 0; i < 400; i++) begin
            Reset      = ($urandom_range(0, 59) == 0);
            D_Addr     = 8'($urandom);
            D_Wr       = 1'($urandom);
            RF_s       = 2'($urandom);
            Imm        = 16'($urandom);
            RF_W_Addr  = 4'($urandom);
            RF_W_en    = 1'($urandom);
            RF_Ra_Addr = 4'($urandom);
            RF_Rb_Addr = 4'($urandom);
            ALU_s      = 3'($urandom);
            Flag_en    = 1'($urandom);
            #1;
            m_alu(ALU_s, m_regs[RF_Ra_Addr], m_regs[RF_Rb_Addr], er, ef);
            n_checks++;
            if (ALU_inA !== m_regs[RF_Ra_Addr] || ALU_inB !== m_regs[RF_Rb_Addr]) begin
                n_errors++;
                $display("FAIL rand_rf[%0d]: got A=%h B=%h want %h %h", i, ALU_inA, ALU_inB,
                         m_regs[RF_Ra_Addr], m_regs[RF_Rb_Addr]);
            end
            n_checks++;
            if (ALU_out !== er) begin
                n_errors++; $display("FAIL rand_alu[%0d] op=%0d: got %h want %h", i, ALU_s, ALU_out, er);
            end
            step();
            n_checks++;
            if (Flags !== m_flags || D_Rd !== m_drd) begin
                n_errors++;
                $display("FAIL rand_seq[%0d]: got F=%b D=%h want %b %h", i, Flags, D_Rd, m_flags, m_drd);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        preload_mem();
        test_imm_add();
        test_flags();
        test_mem();
        test_r0_rdw();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_datapath_p
`default_nettype wire
